cmd_frame_parser: RTL

Upstream feeder for the command-to-bus stage. It takes a byte stream from the host link receiver and assembles framed commands. Each valid frame becomes one command word {rnw, regno, value}, presented with a single-cycle new_cmd strobe that drives the downstream command FIFO write. Malformed frames are discarded and counted.

---
 rtl/cmd_frame_parser.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cmd_frame_parser.sv
// Byte-stream frame parser: SYNC, FLAGS, REG_HI, REG_LO, VAL_HI, VAL_LO -> one command word.
// Define CMD_FRAME_CKSUM_EN to append an XOR checksum byte to every frame.
module cmd_frame_parser #(
  parameter int         REGNO_W   = 16,
  parameter int         VALUE_W   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               cmd_rnw,
  output logic [REGNO_W-1:0] cmd_regno,
  output logic [VALUE_W-1:0] cmd_value,
  output logic               new_cmd,
  output logic               frame_err,
  output logic [7:0]         err_count,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_FLAGS  = 3'd1,
    S_REG_HI = 3'd2,
    S_REG_LO = 3'd3,
    S_VAL_HI = 3'd4,
    S_VAL_LO = 3'd5
`ifdef CMD_FRAME_CKSUM_EN
    , S_CKSUM = 3'd6
`endif
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] idle_cnt_r;
  logic             done_s;
  logic             err_s;
  logic             rnw_r;
  logic [15:0]      reg_r;
  logic [7:0]       val_hi_r;
  logic [15:0]      value_full_s;

`ifdef CMD_FRAME_CKSUM_EN
  logic [7:0] val_lo_r;
  logic [7:0] cksum_r;

  function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  assign value_full_s = {val_hi_r, val_lo_r};
`else
  assign value_full_s = {val_hi_r, rx_data};
`endif

  // Next-state decode; a byte on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    if (rx_valid) begin
      case (state_r)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_nxt_s = S_FLAGS;
          end else begin
            state_nxt_s = S_HUNT;
          end
        end
        S_FLAGS:  state_nxt_s = S_REG_HI;
        S_REG_HI: state_nxt_s = S_REG_LO;
        S_REG_LO: state_nxt_s = S_VAL_HI;
        S_VAL_HI: state_nxt_s = S_VAL_LO;
        S_VAL_LO: begin
`ifdef CMD_FRAME_CKSUM_EN
          state_nxt_s = S_CKSUM;
`else
          state_nxt_s = S_HUNT;
          done_s      = 1'b1;
`endif
        end
`ifdef CMD_FRAME_CKSUM_EN
        S_CKSUM: begin
          state_nxt_s = S_HUNT;
          if (rx_data == cksum_r) begin
            done_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
`endif
        default: state_nxt_s = S_HUNT;
      endcase
    end else if ((state_r != S_HUNT) && (idle_cnt_r == CNT_LAST)) begin
      state_nxt_s = S_HUNT;
      err_s       = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame FSM, field capture, idle timer and registered command/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_HUNT;
      idle_cnt_r <= {CNT_W{1'b0}};
      rnw_r      <= 1'b0;
      reg_r      <= 16'h0000;
      val_hi_r   <= 8'h00;
      cmd_rnw    <= 1'b0;
      cmd_regno  <= {REGNO_W{1'b0}};
      cmd_value  <= {VALUE_W{1'b0}};
      new_cmd    <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s != S_HUNT);
      new_cmd   <= done_s;
      frame_err <= err_s;
      if (err_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      // Idle counter only runs inside a frame between bytes.
      if (rx_valid || (state_nxt_s == S_HUNT)) begin
        idle_cnt_r <= {CNT_W{1'b0}};
      end else begin
        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
      end
      if (rx_valid) begin
        case (state_r)
          S_FLAGS:  rnw_r       <= rx_data[0];
          S_REG_HI: reg_r[15:8] <= rx_data;
          S_REG_LO: reg_r[7:0]  <= rx_data;
          S_VAL_HI: val_hi_r    <= rx_data;
          default:  ;
        endcase
      end
      if (done_s) begin
        cmd_rnw   <= rnw_r;
        cmd_regno <= reg_r[REGNO_W-1:0];
        cmd_value <= value_full_s[VALUE_W-1:0];
      end
    end
  end

`ifdef CMD_FRAME_CKSUM_EN
  // Checksum accumulator and low value byte, held until the CKSUM byte decides the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      cksum_r  <= 8'h00;
      val_lo_r <= 8'h00;
    end else if (rx_valid) begin
      case (state_r)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            cksum_r <= 8'h00;
          end
        end
        S_FLAGS, S_REG_HI, S_REG_LO, S_VAL_HI: cksum_r <= cksum_step(cksum_r, rx_data);
        S_VAL_LO: begin
          cksum_r  <= cksum_step(cksum_r, rx_data);
          val_lo_r <= rx_data;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
